// File: rtl/hpdcache_fifo_out_skid.sv
// Two-entry registered output stage behind a register FIFO; ready_i never reaches fifo_r_o.
// Optional stall counter enabled by HPDCACHE_FIFO_OUT_SKID_STATS_EN.
module hpdcache_fifo_out_skid #(
  parameter type data_t = logic,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   fifo_rok_i,
  output logic                   fifo_r_o,
  input  data_t                  fifo_rdata_i,
  input  logic                   flush_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output data_t                  data_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e state_q, state_d;
  data_t  main_q, main_d;
  data_t  skid_q, skid_d;
  logic   acc;
  logic   dlv;

  assign valid_o  = (state_q != EMPTY);
  assign data_o   = main_q;
  assign fifo_r_o = (state_q != FULL) & ~flush_i & ~rst_i;
  assign acc      = fifo_rok_i & fifo_r_o;
  assign dlv      = valid_o & ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (acc) begin
          main_d  = fifo_rdata_i;
          state_d = HALF;
        end
      end
      HALF: begin
        unique case (1'b1)
          acc && !dlv: begin
            skid_d  = fifo_rdata_i;
            state_d = FULL;
          end
          acc && dlv: main_d = fifo_rdata_i;
          !acc && dlv: state_d = EMPTY;
          default: ;
        endcase
      end
      FULL: begin
        if (dlv) begin
          main_d  = skid_q;
          state_d = HALF;
        end
      end
      default: state_d = EMPTY;
    endcase
    // flush drops skid by leaving it unreachable from EMPTY
    if (flush_i) state_d = EMPTY;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      main_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
    end
  end

  always_ff @(posedge clk_i) begin
    skid_q <= skid_d;
  end

`ifdef HPDCACHE_FIFO_OUT_SKID_STATS_EN
  logic [STALL_CNT_W-1:0] stall_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_q <= '0;
    end else if (valid_o && !ready_i && stall_q != {STALL_CNT_W{1'b1}}) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hpdcache_fifo_out_skid.sv
// Directed bench for hpdcache_fifo_out_skid (8-bit payload, 2-bit stall counter).
// Expected stall values follow HPDCACHE_FIFO_OUT_SKID_STATS_EN.
module tb_hpdcache_fifo_out_skid;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       fifo_rok_i;
  logic       fifo_r_o;
  logic [7:0] fifo_rdata_i;
  logic       flush_i;
  logic       valid_o;
  logic       ready_i;
  logic [7:0] data_o;
  logic [1:0] stall_cnt_o;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  hpdcache_fifo_out_skid #(
    .data_t      (logic [7:0]),
    .STALL_CNT_W (2)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .fifo_rok_i   (fifo_rok_i),
    .fifo_r_o     (fifo_r_o),
    .fifo_rdata_i (fifo_rdata_i),
    .flush_i      (flush_i),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .data_o       (data_o),
    .stall_cnt_o  (stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic drive(input logic rst, input logic rok,
                       input logic [7:0] d, input logic rdy,
                       input logic fl);
    rst_i        = rst;
    fifo_rok_i   = rok;
    fifo_rdata_i = d;
    ready_i      = rdy;
    flush_i      = fl;
    #2;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 8'h55, 1'b0, 1'b0);
    tick();
    tick();
    drive(1'b1, 1'b1, 8'h55, 1'b0, 1'b0);
    tot_cnt++;
    if (valid_o !== 1'b0)
      $display("FAIL reset_valid got=%b exp=0", valid_o);
    else pass_cnt++;
    tot_cnt++;
    if (data_o !== 8'h00)
      $display("FAIL reset_data got=%h exp=00", data_o);
    else pass_cnt++;
    tot_cnt++;
    if (fifo_r_o !== 1'b0)
      $display("FAIL reset_fifo_r got=%b exp=0", fifo_r_o);
    else pass_cnt++;
    tot_cnt++;
    if (stall_cnt_o !== 2'd0)
      $display("FAIL reset_stall got=%0d exp=0", stall_cnt_o);
    else pass_cnt++;
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_stall_cnt();
    logic [1:0] exp_seq [5];
    logic [1:0] e;
    exp_seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    drive(1'b0, 1'b1, 8'h77, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    tot_cnt++;
    if (stall_cnt_o !== 2'd0)
      $display("FAIL stall_init got=%0d exp=0", stall_cnt_o);
    else pass_cnt++;
    for (int k = 0; k < 5; k++) begin
      tick();
      drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
`ifdef HPDCACHE_FIFO_OUT_SKID_STATS_EN
      e = exp_seq[k];
`else
      e = 2'd0;
`endif
      tot_cnt++;
      if (stall_cnt_o !== e)
        $display("FAIL stall_seq%0d got=%0d exp=%0d", k, stall_cnt_o, e);
      else pass_cnt++;
    end
    tot_cnt++;
    if (valid_o !== 1'b1 || data_o !== 8'h77)
      $display("FAIL stall_hold got=%b/%h exp=1/77", valid_o, data_o);
    else pass_cnt++;
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    tot_cnt++;
    if (valid_o !== 1'b0)
      $display("FAIL stall_drain got=%b exp=0", valid_o);
    else pass_cnt++;
  endtask

  task automatic test_latency();
    drive(1'b0, 1'b1, 8'hA1, 1'b1, 1'b0);
    tot_cnt++;
    if (fifo_r_o !== 1'b1 || valid_o !== 1'b0)
      $display("FAIL lat_c0 got=r%b/v%b exp=r1/v0", fifo_r_o, valid_o);
    else pass_cnt++;
    tick();
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    tot_cnt++;
    if (valid_o !== 1'b1 || data_o !== 8'hA1)
      $display("FAIL lat_c1 got=%b/%h exp=1/a1", valid_o, data_o);
    else pass_cnt++;
    tick();
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    tot_cnt++;
    if (valid_o !== 1'b0)
      $display("FAIL lat_c2 got=%b exp=0", valid_o);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 8'(i + 1), 1'b1, 1'b0);
      tot_cnt++;
      if (fifo_r_o !== 1'b1)
        $display("FAIL b2b_r%0d got=%b exp=1", i, fifo_r_o);
      else pass_cnt++;
      if (i > 0) begin
        tot_cnt++;
        if (valid_o !== 1'b1 || data_o !== 8'(i))
          $display("FAIL b2b_d%0d got=%b/%h exp=1/%h", i, valid_o, data_o, 8'(i));
        else pass_cnt++;
      end
      tick();
    end
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    tot_cnt++;
    if (valid_o !== 1'b1 || data_o !== 8'h08)
      $display("FAIL b2b_last got=%b/%h exp=1/08", valid_o, data_o);
    else pass_cnt++;
    tick();
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    tot_cnt++;
    if (valid_o !== 1'b0)
      $display("FAIL b2b_empty got=%b exp=0", valid_o);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    drive(1'b0, 1'b1, 8'h10, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 8'h11, 1'b0, 1'b0);
    tot_cnt++;
    if (fifo_r_o !== 1'b1 || data_o !== 8'h10)
      $display("FAIL bp_half got=r%b/%h exp=r1/10", fifo_r_o, data_o);
    else pass_cnt++;
    tick();
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'b1, 8'h12, 1'b0, 1'b0);
      tot_cnt++;
      if (fifo_r_o !== 1'b0 || valid_o !== 1'b1 || data_o !== 8'h10)
        $display("FAIL bp_full%0d got=r%b/v%b/%h exp=r0/v1/10",
                 k, fifo_r_o, valid_o, data_o);
      else pass_cnt++;
      tick();
    end
    drive(1'b0, 1'b1, 8'h12, 1'b1, 1'b0);
    tot_cnt++;
    if (fifo_r_o !== 1'b0 || data_o !== 8'h10)
      $display("FAIL bp_out0 got=r%b/%h exp=r0/10", fifo_r_o, data_o);
    else pass_cnt++;
    tick();
    drive(1'b0, 1'b1, 8'h12, 1'b1, 1'b0);
    tot_cnt++;
    if (fifo_r_o !== 1'b1 || valid_o !== 1'b1 || data_o !== 8'h11)
      $display("FAIL bp_out1 got=r%b/v%b/%h exp=r1/v1/11",
               fifo_r_o, valid_o, data_o);
    else pass_cnt++;
    tick();
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    tot_cnt++;
    if (valid_o !== 1'b1 || data_o !== 8'h12)
      $display("FAIL bp_out2 got=%b/%h exp=1/12", valid_o, data_o);
    else pass_cnt++;
    tick();
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    tot_cnt++;
    if (valid_o !== 1'b0)
      $display("FAIL bp_empty got=%b exp=0", valid_o);
    else pass_cnt++;
  endtask

  task automatic test_flush();
    logic [1:0] e;
    drive(1'b0, 1'b1, 8'h20, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 8'h21, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 8'h22, 1'b0, 1'b1);
    tot_cnt++;
    if (fifo_r_o !== 1'b0)
      $display("FAIL flush_r got=%b exp=0", fifo_r_o);
    else pass_cnt++;
    tick();
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    tot_cnt++;
    if (valid_o !== 1'b0)
      $display("FAIL flush_valid got=%b exp=0", valid_o);
    else pass_cnt++;
`ifdef HPDCACHE_FIFO_OUT_SKID_STATS_EN
    e = 2'd3;
`else
    e = 2'd0;
`endif
    tot_cnt++;
    if (stall_cnt_o !== e)
      $display("FAIL flush_stall got=%0d exp=%0d", stall_cnt_o, e);
    else pass_cnt++;
    drive(1'b0, 1'b1, 8'h23, 1'b1, 1'b0);
    tot_cnt++;
    if (fifo_r_o !== 1'b1)
      $display("FAIL flush_after_r got=%b exp=1", fifo_r_o);
    else pass_cnt++;
    tick();
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    tot_cnt++;
    if (valid_o !== 1'b1 || data_o !== 8'h23)
      $display("FAIL flush_after_d got=%b/%h exp=1/23", valid_o, data_o);
    else pass_cnt++;
    tick();
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    tot_cnt++;
    if (valid_o !== 1'b0)
      $display("FAIL flush_no_skid got=%b/%h exp=0", valid_o, data_o);
    else pass_cnt++;
  endtask

  task automatic test_reset_in_full();
    drive(1'b0, 1'b1, 8'h30, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 8'h31, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 8'h32, 1'b1, 1'b1);
    tot_cnt++;
    if (fifo_r_o !== 1'b0)
      $display("FAIL rstfull_r got=%b exp=0", fifo_r_o);
    else pass_cnt++;
    tick();
    drive(1'b1, 1'b1, 8'h32, 1'b1, 1'b0);
    tot_cnt++;
    if (valid_o !== 1'b0 || data_o !== 8'h00 || fifo_r_o !== 1'b0)
      $display("FAIL rstfull_out got=v%b/%h/r%b exp=v0/00/r0",
               valid_o, data_o, fifo_r_o);
    else pass_cnt++;
    tot_cnt++;
    if (stall_cnt_o !== 2'd0)
      $display("FAIL rstfull_stall got=%0d exp=0", stall_cnt_o);
    else pass_cnt++;
    tick();
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    tot_cnt++;
    if (valid_o !== 1'b0 || data_o !== 8'h00)
      $display("FAIL rstfull_after got=%b/%h exp=0/00", valid_o, data_o);
    else pass_cnt++;
  endtask

  initial begin
    rst_i        = 1'b1;
    fifo_rok_i   = 1'b0;
    fifo_rdata_i = 8'h00;
    ready_i      = 1'b0;
    flush_i      = 1'b0;
    #1;
    test_reset();
    test_stall_cnt();
    test_latency();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_in_full();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
